// File: rtl/fib_term_buffer.sv
// fib_term_buffer: tags each generated Fibonacci term with a running index and
// a wrap flag, then queues it in a small FIFO behind a valid/ready handshake.
// Terms that arrive while the FIFO is full are dropped and counted.
// Optional macro FIB_CHECK_EN builds a sequence checker driving seq_err.
module fib_term_buffer #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned IDX_W = 16,
  parameter int unsigned LVL_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      in_term,
  input  logic             in_valid,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_term,
  output logic [IDX_W-1:0] out_index,
  output logic             out_wrap,
  output logic             overflow,
  output logic [15:0]      drop_cnt,
  output logic [LVL_W-1:0] level,
  output logic             seq_err
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef struct packed {
    logic [31:0]      term;
    logic [IDX_W-1:0] index;
    logic             wrap;
  } entry_t;

  entry_t             mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [IDX_W-1:0]   idx_cnt;
  logic [31:0]        last_term;
  logic               first;

  logic               pop;
  logic               push;
  logic               drop;
  logic               full;
  logic               wrap_c;
  entry_t             new_ent;
  entry_t             head_n;
  logic [PTR_W-1:0]   rd_ptr_n;
  logic [LVL_W-1:0]   level_n;
  logic [LVL_W-1:0]   occ_after_pop;

  // Handshake decode, tag generation and next head selection.
  always_comb begin
    pop           = out_valid & out_ready;
    full          = (level == LVL_W'(DEPTH));
    push          = in_valid & (~full | pop);
    drop          = in_valid & full & ~pop;
    wrap_c        = ~first & (in_term < last_term);
    new_ent.term  = in_term;
    new_ent.index = idx_cnt;
    new_ent.wrap  = wrap_c;
    rd_ptr_n      = rd_ptr + PTR_W'(pop);
    occ_after_pop = level - LVL_W'(pop);
    level_n       = occ_after_pop + LVL_W'(push);
    // When the FIFO drains to nothing this cycle, the incoming entry becomes head.
    head_n        = (occ_after_pop == '0) ? new_ent : mem[rd_ptr_n];
  end

  // Storage array; entries are only read once written, so no reset needed.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= new_ent;
    end
  end

  // Pointers, occupancy, registered head and status counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      out_valid <= 1'b0;
      out_term  <= '0;
      out_index <= '0;
      out_wrap  <= 1'b0;
      idx_cnt   <= '0;
      last_term <= '0;
      first     <= 1'b1;
      overflow  <= 1'b0;
      drop_cnt  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      rd_ptr    <= rd_ptr_n;
      level     <= level_n;
      out_valid <= (level_n != '0);
      if (level_n != '0) begin
        out_term  <= head_n.term;
        out_index <= head_n.index;
        out_wrap  <= head_n.wrap;
      end
      if (in_valid) begin
        idx_cnt   <= idx_cnt + IDX_W'(1);
        last_term <= in_term;
        first     <= 1'b0;
        if (wrap_c) begin
          overflow <= 1'b1;
        end
      end
      if (drop && (drop_cnt != 16'hFFFF)) begin
        drop_cnt <= drop_cnt + 16'd1;
      end
    end
  end

`ifdef FIB_CHECK_EN
  logic [31:0] t1;
  logic [31:0] t2;
  logic [1:0]  seen;
  logic        seq_err_r;

  // Sticky check that every term from the third onward is the sum of the prior two.
  always_ff @(posedge clk) begin
    if (rst) begin
      t1        <= '0;
      t2        <= '0;
      seen      <= '0;
      seq_err_r <= 1'b0;
    end else if (in_valid) begin
      if ((seen == 2'd2) && (in_term != 32'(t1 + t2))) begin
        seq_err_r <= 1'b1;
      end
      t2 <= t1;
      t1 <= in_term;
      if (seen != 2'd2) begin
        seen <= seen + 2'd1;
      end
    end
  end

  assign seq_err = seq_err_r;
`else
  assign seq_err = 1'b0;
`endif

endmodule
